// File: rtl/nvsram_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : nvsram_pkg
//  Description : Shared types and constants for the NVSRAM pump sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
package nvsram_pkg;

    localparam int TRIM_W = 16;

    localparam logic OP_STORE = 1'b0;
    localparam logic OP_RCL   = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_START   = 3'd2,
        ST_WAIT_HI = 3'd3,
        ST_WAIT_LO = 3'd4,
        ST_RECALL  = 3'd5,
        ST_DONE    = 3'd6
    } state_t;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/nvsram_rr_arb.sv
`default_nettype none
// ============================================================================
//  Module      : nvsram_rr_arb
//  Description : Two-requester round-robin picker; ptr names the favoured one.
//  Revision    : 1.0  initial release
// ============================================================================
module nvsram_rr_arb
    import nvsram_pkg::*;
(
    input  logic [1:0] req,
    input  logic       ptr,
    output logic       gnt,
    output logic       gnt_valid
);

    always_comb begin
        gnt       = 1'b0;
        gnt_valid = |req;
        if (req[ptr]) begin
            gnt = ptr;
        end else begin
            gnt = ~ptr;
        end
    end

endmodule
`default_nettype wire

// File: rtl/nvsram_pump_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : nvsram_pump_sequencer
//  Description : Grants the shared NVSRAM charge pump to MEM1/MEM2 and
//                sequences STORE / RECALL operations through to completion.
//  Revision    : 1.0  initial release
// ============================================================================
module nvsram_pump_sequencer
    import nvsram_pkg::*;
#(
    parameter int SETUP_CYCLES  = 4,
    parameter int START_TIMEOUT = 64,
    parameter int STORE_TIMEOUT = 4096,
    parameter int RCL_CYCLES    = 16
) (
    input  logic              CLKI,
    input  logic              POR,
    input  logic [1:0]        REQ_STORE,
    input  logic [1:0]        REQ_RCL,
    input  logic [TRIM_W-1:0] TRIM_IN,
    input  logic              VSEBUSY,
    output logic [1:0]        ACK,
    output logic              ERR,
    output logic              MEM1_ENT,
    output logic              MEM2_ENT,
    output logic              BUSYNVC,
    output logic              VSESTART,
    output logic              RCLT,
    output logic [TRIM_W-1:0] TRIM,
    output logic              BUSY
);

    localparam int c_cnt_w = $clog2(max4(STORE_TIMEOUT, START_TIMEOUT,
                                         RCL_CYCLES, SETUP_CYCLES) + 1);

    // The START cycle counts as the first cycle of the VSEBUSY-rise window,
    // so the timeout lands START_TIMEOUT cycles after the VSESTART pulse.
    localparam logic [c_cnt_w-1:0] c_setup_ld = c_cnt_w'(SETUP_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_start_ld = c_cnt_w'(START_TIMEOUT - 2);
    localparam logic [c_cnt_w-1:0] c_store_ld = c_cnt_w'(STORE_TIMEOUT - 1);
    localparam logic [c_cnt_w-1:0] c_rcl_ld   = c_cnt_w'(RCL_CYCLES - 1);

    state_t               r_state;
    logic [c_cnt_w-1:0]   r_cnt;
    logic                 r_sel;
    logic                 r_op;
    logic                 r_rr_ptr;

    logic [1:0]           w_req;
    logic                 w_gnt;
    logic                 w_gnt_valid;
    logic                 w_gnt_op;
    logic                 w_to_done;
    logic                 w_timeout;

    assign w_req    = REQ_STORE | REQ_RCL;
    assign w_gnt_op = REQ_RCL[w_gnt] ? OP_RCL : OP_STORE;

    nvsram_rr_arb u_arb (
        .req       (w_req),
        .ptr       (r_rr_ptr),
        .gnt       (w_gnt),
        .gnt_valid (w_gnt_valid)
    );

    // Exits into DONE, shared by the store-wait and recall paths.
    always_comb begin
        w_to_done = 1'b0;
        w_timeout = 1'b0;
        case (r_state)
            ST_WAIT_HI: begin
                if (!VSEBUSY && (r_cnt == '0)) begin
                    w_to_done = 1'b1;
                    w_timeout = 1'b1;
                end
            end
            ST_WAIT_LO: begin
                if (!VSEBUSY) begin
                    w_to_done = 1'b1;
                end else if (r_cnt == '0) begin
                    w_to_done = 1'b1;
                    w_timeout = 1'b1;
                end
            end
            ST_RECALL: begin
                if (r_cnt == '0) begin
                    w_to_done = 1'b1;
                end
            end
            default: begin
                w_to_done = 1'b0;
                w_timeout = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLKI) begin
        if (POR) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_sel    <= 1'b0;
            r_op     <= OP_STORE;
            r_rr_ptr <= 1'b0;
            ACK      <= 2'b00;
            ERR      <= 1'b0;
            MEM1_ENT <= 1'b0;
            MEM2_ENT <= 1'b0;
            BUSYNVC  <= 1'b0;
            VSESTART <= 1'b0;
            RCLT     <= 1'b0;
            TRIM     <= '0;
            BUSY     <= 1'b0;
        end else if (w_to_done) begin
            r_state  <= ST_DONE;
            r_cnt    <= '0;
            ACK      <= r_sel ? 2'b10 : 2'b01;
            ERR      <= w_timeout;
            MEM1_ENT <= 1'b0;
            MEM2_ENT <= 1'b0;
            BUSYNVC  <= 1'b0;
            RCLT     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_gnt_valid) begin
                        r_state  <= ST_SETUP;
                        r_cnt    <= c_setup_ld;
                        r_sel    <= w_gnt;
                        r_op     <= w_gnt_op;
                        TRIM     <= TRIM_IN;
                        MEM1_ENT <= ~w_gnt;
                        MEM2_ENT <= w_gnt;
                        BUSYNVC  <= 1'b1;
                        BUSY     <= 1'b1;
                    end
                end
                ST_SETUP: begin
                    if (r_cnt == '0) begin
                        if (r_op == OP_RCL) begin
                            r_state <= ST_RECALL;
                            r_cnt   <= c_rcl_ld;
                            RCLT    <= 1'b1;
                        end else begin
                            r_state  <= ST_START;
                            r_cnt    <= '0;
                            VSESTART <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_START: begin
                    r_state  <= ST_WAIT_HI;
                    r_cnt    <= c_start_ld;
                    VSESTART <= 1'b0;
                end
                ST_WAIT_HI: begin
                    if (VSEBUSY) begin
                        r_state <= ST_WAIT_LO;
                        r_cnt   <= c_store_ld;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_WAIT_LO: begin
                    r_cnt <= r_cnt - 1'b1;
                end
                ST_RECALL: begin
                    r_cnt <= r_cnt - 1'b1;
                end
                ST_DONE: begin
                    r_state  <= ST_IDLE;
                    r_cnt    <= '0;
                    r_rr_ptr <= ~r_sel;
                    ACK      <= 2'b00;
                    ERR      <= 1'b0;
                    BUSY     <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_nvsram_pump_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nvsram_pump_sequencer
//  Description : Directed bench with an ACK scoreboard for the pump sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_nvsram_pump_sequencer;

    logic        CLKI = 1'b0;
    logic        POR = 1'b1;
    logic [1:0]  REQ_STORE = 2'b00;
    logic [1:0]  REQ_RCL = 2'b00;
    logic [15:0] TRIM_IN = 16'h0000;
    logic        VSEBUSY = 1'b0;
    logic [1:0]  ACK;
    logic        ERR;
    logic        MEM1_ENT;
    logic        MEM2_ENT;
    logic        BUSYNVC;
    logic        VSESTART;
    logic        RCLT;
    logic [15:0] TRIM;
    logic        BUSY;

    nvsram_pump_sequencer dut (
        .CLKI      (CLKI),
        .POR       (POR),
        .REQ_STORE (REQ_STORE),
        .REQ_RCL   (REQ_RCL),
        .TRIM_IN   (TRIM_IN),
        .VSEBUSY   (VSEBUSY),
        .ACK       (ACK),
        .ERR       (ERR),
        .MEM1_ENT  (MEM1_ENT),
        .MEM2_ENT  (MEM2_ENT),
        .BUSYNVC   (BUSYNVC),
        .VSESTART  (VSESTART),
        .RCLT      (RCLT),
        .TRIM      (TRIM),
        .BUSY      (BUSY)
    );

    always #5 CLKI = ~CLKI;

    // cyc equals k throughout the cycle that follows the k-th rising edge
    int cyc = 0;
    always @(posedge CLKI) cyc <= cyc + 1;

    typedef struct {
        logic [1:0]  ack;
        logic        err;
        logic [31:0] due;   // all ones: ACK cycle not checked
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;
    bit   pump_on = 1'b1;
    bit   mem2_seen = 1'b0;
    localparam logic [31:0] c_any = 32'hFFFF_FFFF;

    task automatic note_fail(input string name);
        n_vec++;
        n_bad++;
        $display("FAIL %s: expected DUT event did not occur within its cycle budget", name);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every ACK pops one expected completion.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLKI);
            if (MEM2_ENT) mem2_seen = 1'b1;
            if (MEM1_ENT || MEM2_ENT) begin
                n_vec++;
                if (MEM1_ENT && MEM2_ENT) begin
                    n_bad++;
                    $display("FAIL ent_exclusive: MEM1_ENT=1 MEM2_ENT=1 at cycle %0d, required at most one", cyc);
                end
            end
            if (ACK != 2'b00 || ERR) begin
                n_vec++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_ack: ACK=%b ERR=%b at cycle %0d, none required", ACK, ERR, cyc);
                end else begin
                    e = sb.pop_front();
                    if (ACK !== e.ack || ERR !== e.err) begin
                        n_bad++;
                        $display("FAIL ack_value: ACK=%b ERR=%b, required ACK=%b ERR=%b", ACK, ERR, e.ack, e.err);
                    end
                    if (e.due != c_any) begin
                        n_vec++;
                        if (cyc != int'(e.due)) begin
                            n_bad++;
                            $display("FAIL ack_cycle: ACK at cycle %0d, required cycle %0d", cyc, e.due);
                        end
                    end
                end
            end
        end
    end

    // Pump model: VSEBUSY rises 3 cycles after VSESTART and stays high 20 cycles.
    initial begin
        forever begin
            @(negedge CLKI);
            if (pump_on && VSESTART) begin
                repeat (3) @(posedge CLKI);
                #1 VSEBUSY = 1'b1;
                repeat (20) @(posedge CLKI);
                #1 VSEBUSY = 1'b0;
            end
        end
    end

    task automatic wait_vsestart(input string name, output int s);
        bit ok;
        ok = 1'b0;
        s  = 0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge CLKI);
            if (VSESTART) begin
                ok = 1'b1;
                s  = cyc;
            end
        end
        if (!ok) note_fail(name);
    endtask

    task automatic wait_ack(input string name, input int bound);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < bound && !ok; i++) begin
            @(negedge CLKI);
            if (ACK != 2'b00) ok = 1'b1;
        end
        if (!ok) note_fail(name);
    endtask

    initial begin
        int k;
        int s;
        int ent_cnt;
        int rclt_cnt;
        bit seen_ack;

        // Reset state
        repeat (3) @(negedge CLKI);
        check("reset_outputs", {23'd0, ACK, ERR, MEM1_ENT, MEM2_ENT, BUSYNVC, VSESTART, RCLT, BUSY}, 32'd0);
        check("reset_trim", {16'd0, TRIM}, 32'd0);
        POR = 1'b0;

        // 1. Store on MEM1
        @(posedge CLKI); #1;
        TRIM_IN   = 16'hA5C3;
        REQ_STORE = 2'b01;
        mem2_seen = 1'b0;
        ent_cnt   = 0;
        s         = 0;
        for (int i = 0; i < 20 && s == 0; i++) begin
            @(negedge CLKI);
            if (VSESTART) s = cyc;
            else if (MEM1_ENT && BUSYNVC) ent_cnt++;
        end
        if (s == 0) note_fail("t1_vsestart");
        check("t1_setup_cycles", ent_cnt, 32'd4);
        check("t1_trim", {16'd0, TRIM}, 32'h0000A5C3);
        sb.push_back('{ack: 2'b01, err: 1'b0, due: 32'(s + 24)});
        wait_ack("t1_ack", 60);
        REQ_STORE = 2'b00;
        check("t1_mem2_idle", {31'd0, mem2_seen}, 32'd0);

        // 2. Recall on MEM2: request cycle is the first of 22, ACK in the last
        @(posedge CLKI); #1;
        REQ_RCL = 2'b10;
        k = cyc;
        sb.push_back('{ack: 2'b10, err: 1'b0, due: 32'(k + 21)});
        rclt_cnt = 0;
        seen_ack = 1'b0;
        for (int i = 0; i < 40 && !seen_ack; i++) begin
            @(negedge CLKI);
            if (RCLT) rclt_cnt++;
            if (ACK != 2'b00) seen_ack = 1'b1;
        end
        if (!seen_ack) note_fail("t2_ack");
        REQ_RCL = 2'b00;
        check("t2_rclt_width", rclt_cnt, 32'd16);

        // 3. Contention from reset: alternating grants
        @(negedge CLKI);
        POR       = 1'b1;
        REQ_STORE = 2'b11;
        repeat (2) @(negedge CLKI);
        sb.push_back('{ack: 2'b01, err: 1'b0, due: c_any});
        sb.push_back('{ack: 2'b10, err: 1'b0, due: c_any});
        sb.push_back('{ack: 2'b01, err: 1'b0, due: c_any});
        sb.push_back('{ack: 2'b10, err: 1'b0, due: c_any});
        POR = 1'b0;
        for (int i = 0; i < 4; i++) wait_ack("t3_ack", 80);
        REQ_STORE = 2'b00;

        // 4. Timeout: pump never answers
        pump_on = 1'b0;
        @(posedge CLKI); #1;
        REQ_STORE = 2'b01;
        wait_vsestart("t4_vsestart", s);
        sb.push_back('{ack: 2'b01, err: 1'b1, due: 32'(s + 64)});
        wait_ack("t4_ack", 80);
        REQ_STORE = 2'b00;
        @(negedge CLKI);
        check("t4_idle_after", {31'd0, BUSY}, 32'd0);
        pump_on = 1'b1;

        // 5. Reset during WAIT_LO aborts silently
        @(posedge CLKI); #1;
        TRIM_IN   = 16'h5A5A;
        REQ_STORE = 2'b01;
        wait_vsestart("t5_vsestart", s);
        repeat (10) @(negedge CLKI);
        check("t5_in_wait_lo", {30'd0, VSEBUSY, BUSYNVC}, 32'd3);
        POR       = 1'b1;
        REQ_STORE = 2'b00;
        @(posedge CLKI); #1;
        POR = 1'b0;
        @(negedge CLKI);
        check("t5_por_outputs", {23'd0, ACK, ERR, MEM1_ENT, MEM2_ENT, BUSYNVC, VSESTART, RCLT, BUSY}, 32'd0);
        check("t5_por_trim", {16'd0, TRIM}, 32'd0);
        repeat (30) @(negedge CLKI);
        @(posedge CLKI); #1;
        TRIM_IN   = 16'h1234;
        REQ_STORE = 2'b10;
        wait_vsestart("t5_new_vsestart", s);
        check("t5_new_trim", {16'd0, TRIM}, 32'h00001234);
        check("t5_new_ent", {30'd0, MEM2_ENT, MEM1_ENT}, 32'd2);
        sb.push_back('{ack: 2'b10, err: 1'b0, due: 32'(s + 24)});
        wait_ack("t5_new_ack", 60);
        REQ_STORE = 2'b00;

        // 6. Same requester, recall and store together: recall first
        @(posedge CLKI); #1;
        REQ_RCL   = 2'b01;
        REQ_STORE = 2'b01;
        k = cyc;
        mem2_seen = 1'b0;
        sb.push_back('{ack: 2'b01, err: 1'b0, due: 32'(k + 21)});
        wait_ack("t6_rcl_ack", 40);
        REQ_RCL = 2'b00;
        wait_vsestart("t6_vsestart", s);
        sb.push_back('{ack: 2'b01, err: 1'b0, due: 32'(s + 24)});
        wait_ack("t6_store_ack", 60);
        REQ_STORE = 2'b00;
        check("t6_mem2_idle", {31'd0, mem2_seen}, 32'd0);

        repeat (5) @(negedge CLKI);
        check("scoreboard_drained", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        n_bad++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
